// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache-side request ports and the single backing-memory port
// served by mem_port_arbiter. slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Cache-side ports, packed {M1,M0}
  logic [1:0]              m_req;
  logic [1:0]              m_we;
  logic [2*ADDR_WIDTH-1:0] m_addr;
  logic [2*DATA_WIDTH-1:0] m_wdata;
  logic [1:0]              m_ack;
  logic [1:0]              m_err;
  logic [DATA_WIDTH-1:0]   m_rdata;

  // Backing-memory port
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, mem_ack, mem_rdata,
    output m_ack, m_err, m_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, mem_ack, mem_rdata,
    input  m_ack, m_err, m_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port backing memory: fixed priority with a
// starvation guard, one outstanding transaction, error completion on timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned HIGH_PRIO  = 1,
  parameter int unsigned MAX_CONSEC = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam int unsigned CW = $clog2(MAX_CONSEC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_CONSEC);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);
  localparam logic          HP   = HIGH_PRIO[0];
  localparam logic          LP   = ~HIGH_PRIO[0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic                  grant;
  logic [CW-1:0]         consec;
  logic [TW-1:0]         timer;

  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  mem_done;
  logic                  timed_out;

  // Winner selection; the low-priority master gets one turn once the
  // high-priority master has used up its consecutive-grant allowance.
  always_comb begin
    win = HP;
    unique case (bus.m_req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = (consec == MAXC && grant == HP) ? LP : HP;
      default: win = HP;
    endcase
    sel_we    = bus.m_we[win];
    sel_addr  = win ? bus.m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                    : bus.m_addr[ADDR_WIDTH-1:0];
    sel_wdata = win ? bus.m_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                    : bus.m_wdata[DATA_WIDTH-1:0];
  end

  // Completion is signalled in the same cycle as mem_ack; a mem_ack coinciding
  // with the timeout takes precedence and completes normally.
  always_comb begin
    mem_done    = (state == BUSY) && bus.mem_ack;
    timed_out   = (state == BUSY) && !bus.mem_ack && (timer == TLIM);
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_rdata = '0;
    if (mem_done) begin
      bus.m_ack[grant] = 1'b1;
      bus.m_rdata      = bus.mem_rdata;
    end else if (timed_out) begin
      bus.m_ack[grant] = 1'b1;
      bus.m_err[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= 1'b0;
      consec        <= '0;
      timer         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.m_req) begin
            grant         <= win;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            if (win == HP && bus.m_req[LP])
              consec <= (consec == MAXC) ? consec : consec + CW'(1);
            else
              consec <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          timer <= timer + TW'(1);
          if (bus.mem_ack || timer == TLIM) begin
            bus.mem_req <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          timer <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
